// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key expansion, one word per clock, into a word store.
// Round keys are read back through a registered index port.
module aes_key_schedule #(
   parameter int MAX_NK = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:0]   key_len,
   input  logic [255:0] key_in,
   output logic         busy,
   output logic         done,
   output logic         key_valid,
   output logic         err,
   output logic [3:0]   num_rounds,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk_out
);

   localparam int DEPTH = 4 * (MAX_NK + 7);
   localparam int IW    = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, EXPAND, FINISH} state_t;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r, t;
      r = 8'h00;
      t = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) r = r ^ t;
         t = xtime(t);
      end
      return r;
   endfunction

   // Inverse as x^254 (0 maps to 0), then the affine map with 0x63.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] s, r, o;
      logic [7:0] c;
      c = 8'h63;
      s = x;
      r = 8'h01;
      for (int k = 1; k < 8; k++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      for (int b = 0; b < 8; b++)
         o[b] = r[b] ^ r[(b + 4) % 8] ^ r[(b + 5) % 8]
              ^ r[(b + 6) % 8] ^ r[(b + 7) % 8] ^ c[b];
      return o;
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   state_t          state, state_d;
   logic [31:0]     w [DEPTH];
   logic [IW-1:0]   i;
   logic [3:0]      nk, nr, cnt;
   logic [7:0]      rcon;
   logic [3:0]      nk_new;
   logic            len_ok;
   logic            load, step, err_d;
   logic [IW-1:0]   last_i, base;
   logic [31:0]     prev, back, sub, temp, new_word;
   logic [127:0]    rk_d;

   always_comb begin
      nk_new = 4'd4;
      len_ok = 1'b0;
      unique case (1'b1)
         key_len == 2'b00: begin nk_new = 4'd4; len_ok = (MAX_NK >= 4); end
         key_len == 2'b01: begin nk_new = 4'd6; len_ok = (MAX_NK >= 6); end
         key_len == 2'b10: begin nk_new = 4'd8; len_ok = (MAX_NK >= 8); end
         default:          begin nk_new = 4'd4; len_ok = 1'b0; end
      endcase
   end

   assign last_i = IW'({nr, 2'b11});
   assign busy   = (state == EXPAND);
   assign done   = (state == FINISH);

   always_comb begin
      state_d = state;
      load    = 1'b0;
      step    = 1'b0;
      err_d   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && len_ok) begin
               load    = 1'b1;
               state_d = EXPAND;
            end else if (start) begin
               err_d = 1'b1;
            end
         end
         EXPAND: begin
            step = 1'b1;
            if (i == last_i) state_d = FINISH;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // cnt tracks i mod Nk, so no divider is needed.
   always_comb begin
      prev = w[i - IW'(1)];
      back = w[i - IW'(nk)];
      sub  = subword((cnt == 4'd0) ? {prev[23:0], prev[31:24]} : prev);
      unique case (1'b1)
         cnt == 4'd0:                temp = sub ^ {rcon, 24'h0};
         nk == 4'd8 && cnt == 4'd4:  temp = sub;
         default:                    temp = prev;
      endcase
      new_word = back ^ temp;
   end

   always_comb begin
      base = IW'({rk_idx, 2'b00});
      rk_d = 128'h0;
      if (key_valid && rk_idx <= num_rounds)
         rk_d = {w[base], w[base + IW'(1)], w[base + IW'(2)], w[base + IW'(3)]};
   end

   always_ff @(posedge clk) begin
      if (load) begin
         for (int j = 0; j < MAX_NK; j++)
            if (j < int'(nk_new)) w[j] <= key_in[255 - 32 * j -: 32];
      end
      if (step) w[i] <= new_word;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         key_valid  <= 1'b0;
         num_rounds <= 4'd0;
         err        <= 1'b0;
         rk_out     <= 128'h0;
         i          <= '0;
         nk         <= 4'd4;
         nr         <= 4'd0;
         cnt        <= 4'd0;
         rcon       <= 8'h01;
      end else begin
         state  <= state_d;
         err    <= err_d;
         rk_out <= rk_d;
         if (load) begin
            i         <= IW'(nk_new);
            nk        <= nk_new;
            nr        <= nk_new + 4'd6;
            cnt       <= 4'd0;
            rcon      <= 8'h01;
            key_valid <= 1'b0;
         end
         if (step) begin
            i   <= i + IW'(1);
            cnt <= (cnt == nk - 4'd1) ? 4'd0 : cnt + 4'd1;
            if (cnt == 4'd0) rcon <= xtime(rcon);
            if (state_d == FINISH) begin
               key_valid  <= 1'b1;
               num_rounds <= nr;
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed-vector bench for aes_key_schedule using FIPS-197 example keys.
// Table-driven runs per key length plus reset, err and sweep sequences.
module tb_aes_key_schedule;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [1:0]   key_len;
   logic [255:0] key_in;
   logic         busy, done, key_valid, err;
   logic [3:0]   num_rounds;
   logic [3:0]   rk_idx;
   logic [127:0] rk_out;

   int n_vec = 0;
   int n_err = 0;

   aes_key_schedule #(.MAX_NK(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len),
      .key_in(key_in), .busy(busy), .done(done), .key_valid(key_valid),
      .err(err), .num_rounds(num_rounds), .rk_idx(rk_idx), .rk_out(rk_out)
   );

   always #5 clk = ~clk;

   localparam logic [255:0] K128 =
      {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 =
      {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   typedef struct {
      logic [1:0]   len;
      logic [255:0] key;
      logic [3:0]   nr;
      int           lat;
      logic [127:0] rk0;
      logic [63:0]  rk1_hi;
      logic [31:0]  last_w3;
   } vec_t;

   vec_t          vecs [3];
   logic [127:0]  rk128 [11];

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic rd(input logic [3:0] idx, output logic [127:0] d);
      rk_idx = idx;
      @(posedge clk); #1;
      d = rk_out;
   endtask

   // Launch a run; optionally pulse an extra start mid-expansion.
   task automatic run(input logic [1:0] len, input logic [255:0] key,
                      input int poke, output int lat);
      key_len = len;
      key_in  = key;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 1;
      chk("busy_first", 128'(busy), 128'(1));
      chk("kv_cleared", 128'(key_valid), 128'(0));
      while (!done && lat < 100) begin
         if (lat == poke) begin
            start = 1'b1; key_len = 2'b10; key_in = K256;
         end else begin
            start = 1'b0; key_len = len; key_in = key;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
   endtask

   initial begin
      logic [127:0] d;
      int lat;
      int seen;

      vecs[0] = '{2'b00, K128, 4'd10, 41,
                  128'h2b7e151628aed2a6abf7158809cf4f3c,
                  64'ha0fafe1788542cb1, 32'hb6630ca6};
      vecs[1] = '{2'b01, K192, 4'd12, 47,
                  128'h8e73b0f7da0e6452c810f32b809079e5,
                  64'h62f8ead2522c6b7b, 32'h01002202};
      vecs[2] = '{2'b10, K256, 4'd14, 53,
                  128'h603deb1015ca71be2b73aef0857d7781,
                  64'h1f352c073b6108d7, 32'h706c631e};

      rk128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      rk128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      rk128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      rk128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      rk128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      rk128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      rk128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      rk128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      rk128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      rk128[9]  = 128'hac7766f319fadc2128d12941575c006e;
      rk128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      rst_n = 1'b0; start = 1'b0; key_len = 2'b00;
      key_in = '0; rk_idx = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_kv", 128'(key_valid), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      chk("rst_nr", 128'(num_rounds), 128'(0));
      chk("rst_rk", rk_out, 128'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int v = 0; v < 3; v++) begin
         run(vecs[v].len, vecs[v].key, -1, lat);
         chk("latency", 128'(lat), 128'(vecs[v].lat));
         chk("done_busy", 128'(busy), 128'(0));
         chk("done_kv", 128'(key_valid), 128'(1));
         chk("done_nr", 128'(num_rounds), 128'(vecs[v].nr));
         @(posedge clk); #1;
         chk("done_pulse", 128'(done), 128'(0));
         rd(4'd0, d);
         chk("rk0", d, vecs[v].rk0);
         rd(4'd1, d);
         chk("rk1_hi", 128'(d[127:64]), 128'(vecs[v].rk1_hi));
         rd(vecs[v].nr, d);
         chk("rkN_w3", 128'(d[31:0]), 128'(vecs[v].last_w3));
         rd(vecs[v].nr + 4'd1, d);
         chk("rk_oob", d, 128'h0);
      end

      // Second start during EXPAND must be ignored.
      run(2'b00, K128, 10, lat);
      chk("poke_lat", 128'(lat), 128'(41));
      chk("poke_nr", 128'(num_rounds), 128'(10));

      // Back-to-back sweep: each key one cycle after its index.
      rk_idx = 4'd0;
      for (int k = 0; k <= 10; k++) begin
         @(posedge clk); #1;
         chk("sweep", rk_out, rk128[k]);
         rk_idx = 4'(k + 1);
      end
      @(posedge clk); #1;
      chk("sweep_11", rk_out, 128'h0);

      // Illegal key_len: err pulse, schedule retained.
      key_len = 2'b11; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; key_len = 2'b00;
      chk("err_pulse", 128'(err), 128'(1));
      chk("err_busy", 128'(busy), 128'(0));
      @(posedge clk); #1;
      chk("err_clear", 128'(err), 128'(0));
      chk("err_kv", 128'(key_valid), 128'(1));
      rd(4'd10, d);
      chk("err_rk10", d, rk128[10]);

      // Reset in the middle of an AES-256 run.
      key_len = 2'b10; key_in = K256; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_busy", 128'(busy), 128'(0));
      chk("mid_kv", 128'(key_valid), 128'(0));
      chk("mid_rk", rk_out, 128'h0);
      chk("mid_nr", 128'(num_rounds), 128'(0));
      rst_n = 1'b1;
      seen = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("mid_nodone", 128'(seen), 128'(0));
      run(2'b00, K128, -1, lat);
      chk("post_lat", 128'(lat), 128'(41));
      rd(4'd1, d);
      chk("post_rk1", d, rk128[1]);
      rd(4'd10, d);
      chk("post_rk10", d, rk128[10]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
